// File: rtl/tensor_core_pkg.sv
// Shared constants, operand row type and sequencer state encoding for the
// tensor core job sequencer.
package tensor_core_pkg;
    localparam int TC_DIM        = 8;
    localparam int TC_DATA_WIDTH = 32;

    typedef logic [TC_DIM*TC_DATA_WIDTH-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        WAIT,
        DRAIN
    } tc_seq_state_e;
endpackage

// File: rtl/tc_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// wrapping around NUM_REQ.
module tc_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_valid
);
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand_idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit is enough: rr_ptr + i never exceeds 2*NUM_REQ-2.
            sum = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NUM_REQ)) begin
                sum = sum - (IDW+1)'(NUM_REQ);
            end
            cand_idx = sum[IDW-1:0];
            if (!grant_valid && req[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
                grant       = NUM_REQ'(1) << cand_idx;
            end
        end
    end
endmodule

// File: rtl/tensor_core_seq.sv
// Job sequencer and round-robin arbiter feeding a combinational 8x8 tensor core.
// Optional performance counters are enabled with TENSOR_CORE_SEQ_PERF_EN.
module tensor_core_seq
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int CORE_LAT   = 2,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req,
    output logic [NUM_REQ-1:0]                req_ack,
    output logic [IDW-1:0]                    grant_id,
    output logic                              busy,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [8*DATA_WIDTH-1:0]           in_data,
    output logic [7:0][7:0][DATA_WIDTH-1:0]   core_a,
    output logic [7:0][7:0][DATA_WIDTH-1:0]   core_b,
    input  logic [7:0][7:0][DATA_WIDTH-1:0]   core_result,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [8*DATA_WIDTH-1:0]           out_data,
    output logic [2:0]                        out_row,
    output logic [IDW-1:0]                    out_id,
    output logic                              out_last
`ifdef TENSOR_CORE_SEQ_PERF_EN
    ,
    output logic [31:0]                       perf_jobs,
    output logic [31:0]                       perf_busy
`endif
);
    localparam logic [2:0] LAST_ROW = 3'(TC_DIM - 1);

    tc_seq_state_e state_q, state_d;
    logic [2:0]         row_cnt_q, row_cnt_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [TC_DIM-1:0][TC_DIM-1:0][DATA_WIDTH-1:0] core_a_q, core_a_d;
    logic [TC_DIM-1:0][TC_DIM-1:0][DATA_WIDTH-1:0] core_b_q, core_b_d;
    logic [TC_DIM-1:0][TC_DIM-1:0][DATA_WIDTH-1:0] result_q, result_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDW-1:0]     arb_idx;
    logic               arb_valid;
    logic               in_hs, out_hs;

    tc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (req),
        .rr_ptr      (rr_ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign in_hs  = in_valid & in_ready_q;
    assign out_hs = out_valid_q & out_ready;

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        wait_cnt_d = wait_cnt_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        req_ack_d  = '0;
        core_a_d   = core_a_q;
        core_b_d   = core_b_q;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d    = LOAD_A;
                    grant_id_d = arb_idx;
                    req_ack_d  = arb_grant;
                    row_cnt_d  = 3'd0;
                end
            end
            LOAD_A: begin
                if (in_hs) begin
                    core_a_d[row_cnt_q] = in_data;
                    row_cnt_d = row_cnt_q + 3'd1;
                    if (row_cnt_q == LAST_ROW) state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (in_hs) begin
                    core_b_d[row_cnt_q] = in_data;
                    row_cnt_d = row_cnt_q + 3'd1;
                    if (row_cnt_q == LAST_ROW) begin
                        state_d    = WAIT;
                        wait_cnt_d = 4'(CORE_LAT);
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    result_d  = core_result;
                    state_d   = DRAIN;
                    row_cnt_d = 3'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    row_cnt_d = row_cnt_q + 3'd1;
                    if (row_cnt_q == LAST_ROW) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Status outputs are registered, so they are decoded from the next state.
        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
        out_valid_d = (state_d == DRAIN);
        out_last_d  = (state_d == DRAIN) && (row_cnt_d == LAST_ROW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            req_ack_q   <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            core_a_q    <= '0;
            core_b_q    <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            req_ack_q   <= req_ack_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            core_a_q    <= core_a_d;
            core_b_q    <= core_b_d;
            result_q    <= result_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign core_a    = core_a_q;
    assign core_b    = core_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = result_q[row_cnt_q];
    assign out_row   = row_cnt_q;
    assign out_id    = grant_id_q;
    assign out_last  = out_last_q;

`ifdef TENSOR_CORE_SEQ_PERF_EN
    logic [31:0] perf_jobs_q, perf_jobs_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    always_comb begin
        perf_jobs_d = perf_jobs_q + ((out_hs && out_last_q) ? 32'd1 : 32'd0);
        perf_busy_d = perf_busy_q + ((state_q != IDLE) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_jobs_q <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_jobs_q <= perf_jobs_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign perf_jobs = perf_jobs_q;
    assign perf_busy = perf_busy_q;
`endif
endmodule
